// File: rtl/rr_switch_pkg.sv
// rr_switch_pkg: shared types, constants and the round-robin pick helper
// for the rr_switch_fabric crossbar.
//   DROP_CNT_WIDTH : width of the per-input discarded-word counters.
//   MAX_PORTS      : upper bound on INPUT_QTY supported by rr_pick.
//   rr_pick        : returns {valid, idx} of the first set request bit found
//                    when searching from ptr upwards, wrapping modulo n.
package rr_switch_pkg;

    localparam int DROP_CNT_WIDTH = 16;
    localparam int MAX_PORTS      = 32;
    localparam int PTR_W          = $clog2(MAX_PORTS);

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // req is zero-extended to MAX_PORTS bits by the caller; only the low n
    // bits take part. ptr < n always holds, so one subtraction wraps.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [PTR_W-1:0]     ptr,
                                         input int                   n);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 0; k < n; k++) begin
            cand = int'(ptr) + k;
            if (cand >= n) cand = cand - n;
            if (!pick.valid && req[PTR_W'(cand)]) begin
                pick.valid = 1'b1;
                pick.idx   = PTR_W'(cand);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_switch_fabric_if.sv
// rr_switch_fabric_if: ingress/egress bundle of the crossbar.
//   data_in_valid/ready/data_in/data_in_destination : per-input handshake.
//   data_out_valid/ready/data_out                   : per-output handshake.
//   drop_count                                      : per-input discard counts.
// Modports: master = traffic source/sink side, slave = the fabric.
interface rr_switch_fabric_if
    import rr_switch_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  INPUT_QTY  = 8,
    parameter int  OUTPUT_QTY = 8,
    localparam int DEST_WIDTH = $clog2(OUTPUT_QTY)
);
    logic [INPUT_QTY-1:0]                     data_in_valid;
    logic [INPUT_QTY-1:0]                     data_in_ready;
    logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]     data_in;
    logic [INPUT_QTY-1:0][DEST_WIDTH-1:0]     data_in_destination;
    logic [OUTPUT_QTY-1:0]                    data_out_valid;
    logic [OUTPUT_QTY-1:0]                    data_out_ready;
    logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0]    data_out;
    logic [INPUT_QTY-1:0][DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output data_in_valid, data_in, data_in_destination, data_out_ready,
        input  data_in_ready, data_out_valid, data_out, drop_count
    );

    modport slave (
        input  data_in_valid, data_in, data_in_destination, data_out_ready,
        output data_in_ready, data_out_valid, data_out, drop_count
    );
endinterface

// File: rtl/switch_input_fifo.sv
// switch_input_fifo: per-input word buffer holding {destination, data}.
//   push/push_dest/push_data : write one word (caller guarantees !full).
//   pop                      : drop head word (caller guarantees !empty).
//   full/empty               : registered occupancy flags.
//   head_data/head_dest      : word at the read pointer.
module switch_input_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DEST_WIDTH-1:0] push_dest,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [DEST_WIDTH-1:0] head_dest
);
    localparam int DEPTH_BITS = $clog2(FIFO_DEPTH);

    logic [DEST_WIDTH+DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DEPTH_BITS-1:0]            wr_ptr;
    logic [DEPTH_BITS-1:0]            rd_ptr;
    logic [DEPTH_BITS:0]              count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the count qualifies every read,
    // so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_dest, push_data};
    end

    assign full                   = (count == (DEPTH_BITS+1)'(FIFO_DEPTH));
    assign empty                  = (count == '0);
    assign {head_dest, head_data} = mem[rd_ptr];

endmodule

// File: rtl/rr_switch_fabric.sv
// rr_switch_fabric: buffered N x M crossbar with per-output round-robin
// arbitration and registered valid/ready output stages.
//   clk, reset_n : clock, asynchronous active-low reset.
//   bus (slave)  : ingress handshake, egress handshake, drop_count.
// Build option: define RR_SWITCH_DROP_COUNT_EN to implement the per-input
// 16-bit saturating counters of words discarded for an out-of-range
// destination; otherwise drop_count reads 0 (discarding still happens).
module rr_switch_fabric
    import rr_switch_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  INPUT_QTY  = 8,
    parameter int  OUTPUT_QTY = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int DEST_WIDTH = $clog2(OUTPUT_QTY)
) (
    input logic               clk,
    input logic               reset_n,
    rr_switch_fabric_if.slave bus
);
    localparam int IDX_W = $clog2(INPUT_QTY);

    logic [INPUT_QTY-1:0]                  full, empty, push, pop, dest_ok;
    logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]  head_data;
    logic [INPUT_QTY-1:0][DEST_WIDTH-1:0]  head_dest;
    logic [OUTPUT_QTY-1:0][INPUT_QTY-1:0]  req_mat;
    logic [OUTPUT_QTY-1:0]                 grant;
    logic [OUTPUT_QTY-1:0][IDX_W-1:0]      grant_idx;

    // Ready depends on registered occupancy only, never on this cycle's pop.
    assign bus.data_in_ready = ~full;

    for (genvar i = 0; i < INPUT_QTY; i++) begin : g_in
        assign dest_ok[i] = (int'(bus.data_in_destination[i]) < OUTPUT_QTY);
        // Words for a non-existent output complete the handshake but are
        // never stored.
        assign push[i]    = bus.data_in_valid[i] && !full[i] && dest_ok[i];

        switch_input_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[i]),
            .push_dest (bus.data_in_destination[i]),
            .push_data (bus.data_in[i]),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head_data (head_data[i]),
            .head_dest (head_dest[i])
        );
    end

`ifdef RR_SWITCH_DROP_COUNT_EN
    for (genvar i = 0; i < INPUT_QTY; i++) begin : g_drop
        logic                      drop;
        logic [DROP_CNT_WIDTH-1:0] cnt_q;
        assign drop = bus.data_in_valid[i] && !full[i] && !dest_ok[i];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                cnt_q <= '0;
            else if (drop && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        assign bus.drop_count[i] = cnt_q;
    end
`else
    assign bus.drop_count = '0;
`endif

    // Each non-empty FIFO requests exactly the output named by its head.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        req_mat = '0;
        for (int j = 0; j < OUTPUT_QTY; j++) begin
            for (int i = 0; i < INPUT_QTY; i++) begin
                req_mat[j][i] = !empty[i] && (head_dest[i] == DEST_WIDTH'(j));
            end
        end
    end

    // An input requests one output at most, so at most one grant hits it.
    always_comb begin
        pop = '0;
        for (int j = 0; j < OUTPUT_QTY; j++) begin
            for (int i = 0; i < INPUT_QTY; i++) begin
                if (grant[j] && grant_idx[j] == IDX_W'(i)) pop[i] = 1'b1;
            end
        end
    end

    for (genvar j = 0; j < OUTPUT_QTY; j++) begin : g_out
        logic                  free;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic [IDX_W-1:0]      rr_ptr;
        rr_pick_t              pick;

        // A stalled output (valid & !ready) grants nothing, so its
        // requesters simply keep their heads.
        assign free         = !valid_q || bus.data_out_ready[j];
        assign pick         = rr_pick(MAX_PORTS'(req_mat[j]), PTR_W'(rr_ptr), INPUT_QTY);
        assign grant[j]     = free && pick.valid;
        assign grant_idx[j] = IDX_W'(pick.idx);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                rr_ptr  <= '0;
            end else if (grant[j]) begin
                valid_q <= 1'b1;
                data_q  <= head_data[grant_idx[j]];
                rr_ptr  <= (grant_idx[j] == IDX_W'(INPUT_QTY - 1)) ? '0
                                                                   : grant_idx[j] + 1'b1;
            end else if (free) begin
                // Consumed with nothing to replace it: data keeps last value.
                valid_q <= 1'b0;
            end
        end

        assign bus.data_out_valid[j] = valid_q;
        assign bus.data_out[j]       = data_q;
    end

endmodule
